pwm_ramp_sequencer: RTL and testbench

//   Controller for the PWM signal generator. Sequences its duty-cycle input through a repeating

---
 rtl/pwm_seq_pkg.sv | 44 ++++
 rtl/pwm_ramp_sequencer_if.sv | 37 +++
 rtl/pwm_seq_dwell_cnt.sv | 32 +++
 rtl/pwm_ramp_sequencer.sv | 162 ++++++++++++++++
 tb/tb_pwm_ramp_sequencer.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pwm_seq_pkg.sv
// Shared types and helpers for the PWM ramp sequencer.
// Latency: n/a (types, constants and a combinational helper only).
// Backpressure: n/a.
package pwm_seq_pkg;

  localparam int DUTY_W_DEF  = 8;
  localparam int DWELL_W_DEF = 8;
  localparam int CYC_W_DEF   = 8;

  // Working width of sat_step; callers zero-extend into it and truncate the result.
  localparam int SAT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RAMP_UP = 3'd1,
    ST_HOLD_HI = 3'd2,
    ST_RAMP_DN = 3'd3,
    ST_HOLD_LO = 3'd4
  } state_e;

  // Saturating step towards a bound. Two extra signed bits mean the add cannot
  // wrap and the subtract cannot underflow before the clamp is applied.
  function automatic logic [SAT_W-1:0] sat_step(input logic [SAT_W-1:0] duty,
                                                input logic [SAT_W-1:0] step,
                                                input logic [SAT_W-1:0] bound,
                                                input logic             dir_up);
    logic signed [SAT_W+1:0] d;
    logic signed [SAT_W+1:0] s;
    logic signed [SAT_W+1:0] b;
    logic signed [SAT_W+1:0] r;
    d = $signed({2'b00, duty});
    s = $signed({2'b00, step});
    b = $signed({2'b00, bound});
    if (dir_up) begin
      r = d + s;
      if (r > b) r = b;
    end else begin
      r = d - s;
      if (r < b) r = b;
    end
    return r[SAT_W-1:0];
  endfunction

endpackage

// File: rtl/pwm_ramp_sequencer_if.sv
// Control/status bundle between the config source and the ramp sequencer.
// Latency: none (wires only).
// Backpressure: none; period_done is a strobe, start/stop are pulses/levels.
// master drives start/stop/period_done/cfg_*; slave (the sequencer) drives
// duty_out, duty_update, busy, done, cfg_err, state_out.
interface pwm_ramp_sequencer_if
  import pwm_seq_pkg::*;
#(
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int CYC_W   = CYC_W_DEF
);
  logic               start;
  logic               stop;
  logic               period_done;
  logic [DUTY_W-1:0]  cfg_min;
  logic [DUTY_W-1:0]  cfg_max;
  logic [DUTY_W-1:0]  cfg_step;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [CYC_W-1:0]   cfg_cycles;
  logic [DUTY_W-1:0]  duty_out;
  logic               duty_update;
  logic               busy;
  logic               done;
  logic               cfg_err;
  logic [2:0]         state_out;

  modport master (
    output start, stop, period_done, cfg_min, cfg_max, cfg_step, cfg_dwell, cfg_cycles,
    input  duty_out, duty_update, busy, done, cfg_err, state_out
  );

  modport slave (
    input  start, stop, period_done, cfg_min, cfg_max, cfg_step, cfg_dwell, cfg_cycles,
    output duty_out, duty_update, busy, done, cfg_err, state_out
  );
endinterface

// File: rtl/pwm_seq_dwell_cnt.sv
// Loadable down-counter with zero flag; stops at zero rather than wrapping.
// Latency: load/decrement visible one clock later; zero_o is combinational on the count.
// Backpressure: none; load_i wins over dec_i.
// Ports: clk, rst (async active-high), load_i/load_val_i, dec_i, zero_o.
module pwm_seq_dwell_cnt
  import pwm_seq_pkg::*;
#(
  parameter int W = DWELL_W_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         dec_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/pwm_ramp_sequencer.sv
// Trapezoidal duty sequencer: ramp up, hold high, ramp down, hold low, repeat.
// Latency: period_done/start/stop to duty_out/duty_update is one clock (registered).
// Backpressure: none; duty only moves on period_done so the PWM core never sees a cut pulse.
// Ports: clk, rst (async active-high), bus (slave modport: start, stop, period_done,
// cfg_* in; duty_out, duty_update, busy, done, cfg_err, state_out out).
module pwm_ramp_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int DUTY_W  = DUTY_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF,
  parameter int CYC_W   = CYC_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  pwm_ramp_sequencer_if.slave  bus
);

  state_e             state_q, state_d;
  logic [DUTY_W-1:0]  duty_q, duty_d;
  logic               upd_q, upd_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Config latched at an accepted start.
  logic [DUTY_W-1:0]  min_q, max_q, step_q;
  logic [DWELL_W-1:0] dwell_q;
  logic               inf_q;
  logic               cfg_ld;

  logic               dwell_ld, dwell_dec, dwell_zero;
  logic               cyc_ld, cyc_dec, cyc_zero;
  logic [DUTY_W-1:0]  up_nxt, dn_nxt;

  // The cycle counter holds the number of full cycles still to run AFTER the
  // current one, so "zero at HOLD_LO exit" means this was the last cycle.
  pwm_seq_dwell_cnt #(.W(DWELL_W)) u_dwell_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (dwell_ld),
    .load_val_i (dwell_q),
    .dec_i      (dwell_dec),
    .zero_o     (dwell_zero)
  );

  pwm_seq_dwell_cnt #(.W(CYC_W)) u_cyc_cnt (
    .clk        (clk),
    .rst        (rst),
    .load_i     (cyc_ld),
    .load_val_i (bus.cfg_cycles - CYC_W'(1)),
    .dec_i      (cyc_dec),
    .zero_o     (cyc_zero)
  );

  assign up_nxt = DUTY_W'(sat_step(SAT_W'(duty_q), SAT_W'(step_q), SAT_W'(max_q), 1'b1));
  assign dn_nxt = DUTY_W'(sat_step(SAT_W'(duty_q), SAT_W'(step_q), SAT_W'(min_q), 1'b0));

  always_comb begin
    state_d   = state_q;
    duty_d    = duty_q;
    upd_d     = 1'b0;
    done_d    = 1'b0;
    err_d     = 1'b0;
    cfg_ld    = 1'b0;
    dwell_ld  = 1'b0;
    dwell_dec = 1'b0;
    cyc_ld    = 1'b0;
    cyc_dec   = 1'b0;

    if (state_q == ST_IDLE) begin
      // start beats a simultaneous stop here; stop alone does nothing in IDLE.
      if (bus.start) begin
        if (bus.cfg_min >= bus.cfg_max) begin
          err_d = 1'b1;
        end else begin
          cfg_ld  = 1'b1;
          cyc_ld  = 1'b1;
          duty_d  = bus.cfg_min;
          upd_d   = 1'b1;
          state_d = ST_RAMP_UP;
        end
      end
    end else if (bus.stop) begin
      state_d = ST_IDLE;
      duty_d  = '0;
      upd_d   = 1'b1;
    end else if (bus.period_done) begin
      case (state_q)
        ST_RAMP_UP: begin
          duty_d = up_nxt;
          upd_d  = (up_nxt != duty_q);
          if (up_nxt == max_q) begin
            state_d  = ST_HOLD_HI;
            dwell_ld = 1'b1;
          end
        end
        ST_HOLD_HI: begin
          if (dwell_zero) state_d = ST_RAMP_DN;
          else            dwell_dec = 1'b1;
        end
        ST_RAMP_DN: begin
          duty_d = dn_nxt;
          upd_d  = (dn_nxt != duty_q);
          if (dn_nxt == min_q) begin
            state_d  = ST_HOLD_LO;
            dwell_ld = 1'b1;
          end
        end
        ST_HOLD_LO: begin
          if (!dwell_zero) begin
            dwell_dec = 1'b1;
          end else if (inf_q) begin
            state_d = ST_RAMP_UP;
          end else if (cyc_zero) begin
            done_d  = 1'b1;
            state_d = ST_IDLE;
          end else begin
            cyc_dec = 1'b1;
            state_d = ST_RAMP_UP;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      duty_q  <= '0;
      upd_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      min_q   <= '0;
      max_q   <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      inf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      duty_q  <= duty_d;
      upd_q   <= upd_d;
      done_q  <= done_d;
      err_q   <= err_d;
      if (cfg_ld) begin
        min_q   <= bus.cfg_min;
        max_q   <= bus.cfg_max;
        // A zero step would never leave RAMP_UP; treat it as 1.
        step_q  <= (bus.cfg_step == '0) ? DUTY_W'(1) : bus.cfg_step;
        dwell_q <= bus.cfg_dwell;
        inf_q   <= (bus.cfg_cycles == '0);
      end
    end
  end

  assign bus.duty_out    = duty_q;
  assign bus.duty_update = upd_q;
  assign bus.busy        = (state_q != ST_IDLE);
  assign bus.done        = done_q;
  assign bus.cfg_err     = err_q;
  assign bus.state_out   = state_q;

endmodule

// File: tb/tb_pwm_ramp_sequencer.sv
module tb_pwm_ramp_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pwm_ramp_sequencer_if bus ();

  pwm_ramp_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tot  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t", nm, act, exp, $time);
  endtask

  // ---------------- behavioural model ----------------
  // On start the whole up/down cycle is unrolled into a list: entry k is the
  // duty and state after the k-th period_done of a cycle.
  int prof_v[$];
  int prof_s[$];
  int m_len, m_idx, m_cyc, m_k;
  bit m_inf, m_busy, m_upd, m_done, m_err;
  int m_duty, m_state;

  task automatic build(input int mn, input int mx, input int st, input int dw);
    int v;
    prof_v.delete();
    prof_s.delete();
    if (st == 0) st = 1;
    v = mn;
    while (v < mx) begin
      v = (v + st > mx) ? mx : v + st;
      prof_v.push_back(v);
      prof_s.push_back((v == mx) ? 2 : 1);
    end
    for (int i = 0; i <= dw; i++) begin
      prof_v.push_back(mx);
      prof_s.push_back((i == dw) ? 3 : 2);
    end
    while (v > mn) begin
      v = (v - st < mn) ? mn : v - st;
      prof_v.push_back(v);
      prof_s.push_back((v == mn) ? 4 : 3);
    end
    for (int i = 0; i <= dw; i++) begin
      prof_v.push_back(mn);
      prof_s.push_back((i == dw) ? 1 : 4);
    end
    m_len = prof_v.size();
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_duty = 0; m_upd = 0; m_done = 0; m_err = 0; m_state = 0;
      m_idx = 0; m_cyc = 0; m_inf = 0;
    end else begin
      m_upd = 0; m_done = 0; m_err = 0;
      if (!m_busy) begin
        if (bus.start) begin
          if (int'(bus.cfg_min) >= int'(bus.cfg_max)) begin
            m_err = 1;
          end else begin
            build(bus.cfg_min, bus.cfg_max, bus.cfg_step, bus.cfg_dwell);
            m_duty = bus.cfg_min; m_upd = 1; m_busy = 1; m_state = 1;
            m_idx = 0; m_cyc = bus.cfg_cycles; m_inf = (bus.cfg_cycles == 0);
          end
        end
      end else if (bus.stop) begin
        m_busy = 0; m_duty = 0; m_upd = 1; m_state = 0;
      end else if (bus.period_done) begin
        m_k = m_idx % m_len;
        m_upd = (prof_v[m_k] != m_duty);
        m_duty = prof_v[m_k];
        m_state = prof_s[m_k];
        m_idx++;
        if (!m_inf && m_idx == m_len * m_cyc) begin
          m_done = 1; m_busy = 0; m_state = 0;
        end
      end
    end
  end

  // Compare process: outputs are registered, so sample on the falling edge.
  always @(negedge clk) begin
    if (!rst && chk_en) begin
      chk("duty_out",    bus.duty_out,    m_duty);
      chk("duty_update", bus.duty_update, m_upd);
      chk("busy",        bus.busy,        m_busy);
      chk("done",        bus.done,        m_done);
      chk("cfg_err",     bus.cfg_err,     m_err);
      chk("state_out",   bus.state_out,   m_state);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cyc(input bit s, input bit p, input bit d);
    bus.start = s; bus.stop = p; bus.period_done = d;
    @(negedge clk);
    bus.start = 0; bus.stop = 0; bus.period_done = 0;
  endtask

  task automatic set_cfg(input int mn, input int mx, input int st, input int dw, input int cy);
    bus.cfg_min = 8'(mn); bus.cfg_max = 8'(mx); bus.cfg_step = 8'(st);
    bus.cfg_dwell = 8'(dw); bus.cfg_cycles = 8'(cy);
  endtask

  task automatic rnd_cfg();
    int mn;
    mn = $urandom_range(0, 240);
    set_cfg(mn, ($urandom_range(0, 9) == 0) ? mn : mn + $urandom_range(1, 15),
            $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 3));
  endtask

  task automatic pd_cap(output int v, output int dn);
    cyc(0, 0, 1);
    v  = bus.duty_out;
    dn = bus.done;
    repeat ($urandom_range(0, 2)) cyc(0, 0, 0);
  endtask

  task automatic run_to_idle(input string nm);
    int n, v, dn;
    n = 0;
    while (bus.busy && n < 2000) begin
      pd_cap(v, dn);
      n++;
    end
    chk(nm, bus.busy, 0);
  endtask

  int exp2[10] = '{20, 30, 40, 40, 40, 30, 20, 10, 10, 10};
  int exp3[8]  = '{100, 200, 255, 255, 155, 55, 0, 0};
  int pat6[6]  = '{2, 4, 4, 2, 0, 0};

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int v, dn, n, ch;
    bus.start = 0; bus.stop = 0; bus.period_done = 0;
    set_cfg(0, 0, 0, 0, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    chk("reset_duty", bus.duty_out, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_state", bus.state_out, 0);
    chk("reset_update", bus.duty_update, 0);
    chk_en = 1;

    // Async reset mid RAMP_UP at duty 40.
    set_cfg(10, 200, 10, 0, 1);
    cyc(1, 0, 0);
    n = 0;
    while (bus.duty_out != 40 && n < 10) begin pd_cap(v, dn); n++; end
    chk("t1_reached40", bus.duty_out, 40);
    chk("t1_state_up", bus.state_out, 1);
    chk_en = 0;
    #2 rst = 1;
    #1;
    chk("t1_async_duty", bus.duty_out, 0);
    chk("t1_async_busy", bus.busy, 0);
    chk("t1_async_state", bus.state_out, 0);
    @(negedge clk);
    rst = 0;
    chk_en = 1;

    // Worked trapezoid with dwell 1.
    set_cfg(10, 40, 10, 1, 1);
    cyc(1, 0, 0);
    chk("t2_start_duty", bus.duty_out, 10);
    chk("t2_start_upd", bus.duty_update, 1);
    for (int i = 0; i < 10; i++) begin
      pd_cap(v, dn);
      chk($sformatf("t2_duty%0d", i), v, exp2[i]);
      chk($sformatf("t2_done%0d", i), dn, (i == 9) ? 1 : 0);
    end
    chk("t2_busy_end", bus.busy, 0);

    // Saturation at the top, no underflow at the bottom.
    set_cfg(0, 255, 100, 0, 1);
    cyc(1, 0, 0);
    for (int i = 0; i < 8; i++) begin
      pd_cap(v, dn);
      chk($sformatf("t3_duty%0d", i), v, exp3[i]);
    end
    chk("t3_done", dn, 1);

    // Rejected start, then zero step.
    set_cfg(50, 50, 5, 0, 1);
    cyc(1, 0, 0);
    chk("t4_cfg_err", bus.cfg_err, 1);
    chk("t4_busy", bus.busy, 0);
    cyc(0, 0, 0);
    chk("t4_err_pulse", bus.cfg_err, 0);
    set_cfg(5, 8, 0, 0, 1);
    cyc(1, 0, 0);
    pd_cap(v, dn);
    chk("t4_step0_a", v, 6);
    pd_cap(v, dn);
    chk("t4_step0_b", v, 7);
    run_to_idle("t4_idle");

    // Start while busy ignored; stop beats period_done in RAMP_DN.
    set_cfg(10, 40, 10, 0, 2);
    cyc(1, 0, 0);
    n = 0;
    while (bus.state_out != 3 && n < 50) begin pd_cap(v, dn); n++; end
    chk("t5_in_ramp_dn", bus.state_out, 3);
    set_cfg(60, 20, 1, 0, 1);
    cyc(1, 0, 0);
    chk("t5_busy_start_err", bus.cfg_err, 0);
    chk("t5_busy_kept", bus.busy, 1);
    cyc(0, 1, 1);
    chk("t5_stop_duty", bus.duty_out, 0);
    chk("t5_stop_busy", bus.busy, 0);
    chk("t5_stop_done", bus.done, 0);
    chk("t5_stop_upd", bus.duty_update, 1);

    // Infinite mode.
    set_cfg(0, 4, 2, 0, 0);
    cyc(1, 0, 0);
    chk("t6_start_duty", bus.duty_out, 0);
    for (int i = 0; i < 20; i++) begin
      pd_cap(v, dn);
      chk($sformatf("t6_duty%0d", i), v, pat6[i % 6]);
      chk($sformatf("t6_nodone%0d", i), dn, 0);
    end
    chk("t6_busy", bus.busy, 1);
    cyc(0, 1, 0);

    // Randomized profiles with stray starts, stops and config churn.
    for (int r = 0; r < 25; r++) begin
      rnd_cfg();
      cyc(1, 0, 0);
      n = 0;
      while (bus.busy && n < 300) begin
        ch = $urandom_range(0, 99);
        if (ch < 2) begin
          cyc(0, 1, $urandom_range(0, 1));
        end else if (ch < 10) begin
          rnd_cfg();
          cyc(1, $urandom_range(0, 1), $urandom_range(0, 1));
        end else begin
          pd_cap(v, dn);
        end
        n++;
      end
      if (bus.busy) cyc(0, 1, 0);
      cyc(0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
